// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, FSM states and
// the legal-opcode check used when an operation is accepted.
package alu_defs;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic alu_op_legal(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_XOR: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The priority pointer moves to the other
// requester only when a grant is actually accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id,
  output logic       accept
);

  logic prio;

  always_comb begin
    gnt_id = 1'b0;
    case (req)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = prio;
      default: gnt_id = 1'b0;
    endcase
    gnt = 2'b00;
    if (en && |req) gnt = gnt_id ? 2'b10 : 2'b01;
    accept = |(gnt & req);
  end

  always_ff @(posedge clk) begin
    if (rst)         prio <= 1'b0;
    else if (accept) prio <= ~gnt_id;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: accept one op, drive it
// to the ALU for a cycle, then hold the captured result until consumed.
module alu_arbiter
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_dout,
  input  logic             alu_zero,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_dout,
  output logic             rsp_zero,
  output logic             rsp_err,
  input  logic             rsp_ready
);

  state_t           state;
  logic [1:0]       gnt;
  logic             gnt_id, accept;
  logic             gnt_id_q, err_q;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_A, sel_B;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .en     (state == IDLE),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .accept (accept)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    sel_op = gnt_id ? req1_op : req0_op;
    sel_A  = gnt_id ? req1_A  : req0_A;
    sel_B  = gnt_id ? req1_B  : req0_B;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_op    <= '0;
      gnt_id_q  <= 1'b0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_dout  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          alu_A    <= sel_A;
          alu_B    <= sel_B;
          alu_op   <= sel_op;
          gnt_id_q <= gnt_id;
          err_q    <= ~alu_op_legal(sel_op);
          state    <= EXEC;
        end
        EXEC: begin
          // Illegal ops report a clean zero result rather than ALU garbage.
          rsp_id    <= gnt_id_q;
          rsp_err   <= err_q;
          rsp_dout  <= err_q ? '0 : alu_dout;
          rsp_zero  <= err_q ? 1'b0 : alu_zero;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: alu_arbiter plus a behavioural shared ALU, checked against
// hand-computed results.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_A, req0_B, req1_A, req1_B, alu_A, alu_B, alu_dout, rsp_dout;
  logic        alu_zero, rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_ready;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_A(req0_A), .req0_B(req0_B), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_A(req1_A), .req1_B(req1_B), .req1_ready(req1_ready),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_dout(alu_dout), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_dout(rsp_dout), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );

  // Shared ALU; unsupported opcodes produce a marker value that must never
  // reach the response.
  always_comb begin
    case (alu_op)
      4'b0000: alu_dout = alu_A & alu_B;
      4'b0001: alu_dout = alu_A | alu_B;
      4'b0010: alu_dout = alu_A + alu_B;
      4'b0110: alu_dout = alu_A - alu_B;
      4'b1100: alu_dout = ~(alu_A | alu_B);
      4'b1101: alu_dout = alu_A ^ alu_B;
      default: alu_dout = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_dout == 32'h0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    if (id) begin req1_valid = 1; req1_op = op; req1_A = a; req1_B = b; end
    else    begin req0_valid = 1; req0_op = op; req0_A = a; req0_B = b; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 10) begin tick(); n++; end
    chk("issue_ready", {31'b0, (id ? req1_ready : req0_ready)}, 32'd1);
    tick();
    if (id) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 10) begin tick(); n++; end
    chk("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    rst = 1; rsp_ready = 1;
    req0_valid = 0; req0_op = 0; req0_A = 0; req0_B = 0;
    req1_valid = 0; req1_op = 0; req1_A = 0; req1_B = 0;
    do_reset();

    // Reset state
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_alu_op", {28'b0, alu_op}, 0);
    chk("rst_alu_A", alu_A, 0);
    chk("rst_rsp_dout", rsp_dout, 0);

    // Single op with exact latency
    req0_valid = 1; req0_op = 4'b0010; req0_A = 32'h0000BEEF; req0_B = 32'h0000CAFE;
    #1;
    chk("single_ready_c0", {31'b0, req0_ready}, 1);
    tick(); req0_valid = 0;
    chk("single_alu_A", alu_A, 32'h0000BEEF);
    chk("single_valid_c1", {31'b0, rsp_valid}, 0);
    tick();
    chk("single_valid_c2", {31'b0, rsp_valid}, 1);
    chk("single_dout", rsp_dout, 32'h000189ED);
    chk("single_id", {31'b0, rsp_id}, 0);
    chk("single_zero", {31'b0, rsp_zero}, 0);
    chk("single_err", {31'b0, rsp_err}, 0);
    tick();
    chk("single_done", {31'b0, rsp_valid}, 0);

    // Contention: fresh pointer, grants alternate starting at requester 0
    do_reset();
    req0_valid = 1; req0_op = 4'b0000; req0_A = 32'h0000BEEF; req0_B = 32'h0000CAFE;
    req1_valid = 1; req1_op = 4'b0110; req1_A = 32'h0000BEEF; req1_B = 32'h0000CAFE;
    for (int k = 0; k < 4; k++) begin
      wait_rsp();
      chk("cont_id", {31'b0, rsp_id}, (k % 2));
      chk("cont_dout", rsp_dout, (k % 2) ? 32'hFFFFF3F1 : 32'h00008AEE);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick(); tick(); tick();

    // Zero result
    issue(0, 4'b0110, 32'h5, 32'h5);
    wait_rsp();
    chk("zero_dout", rsp_dout, 0);
    chk("zero_flag", {31'b0, rsp_zero}, 1);
    chk("zero_err", {31'b0, rsp_err}, 0);
    tick();

    // Illegal opcode
    issue(1, 4'b0111, 32'h0000BEEF, 32'h0000CAFE);
    wait_rsp();
    chk("err_flag", {31'b0, rsp_err}, 1);
    chk("err_dout", rsp_dout, 0);
    chk("err_zero", {31'b0, rsp_zero}, 0);
    chk("err_id", {31'b0, rsp_id}, 1);
    tick();

    // Backpressure: response held while a competing request is refused
    rsp_ready = 0;
    issue(0, 4'b1100, 32'h0000BEEF, 32'h0000CAFE);
    wait_rsp();
    req1_valid = 1; req1_op = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", {31'b0, rsp_valid}, 1);
      chk("bp_dout", rsp_dout, 32'hFFFF0100);
      chk("bp_req1_ready", {31'b0, req1_ready}, 0);
      tick();
    end
    req1_valid = 0; rsp_ready = 1;
    tick();
    chk("bp_release", {31'b0, rsp_valid}, 0);
    req0_valid = 1; req0_op = 4'b0000; #1;
    chk("bp_idle_ready", {31'b0, req0_ready}, 1);
    req0_valid = 0; #1;

    // Reset while the XOR is in EXEC; the pointer had moved to requester 1
    issue(0, 4'b1101, 32'h0000BEEF, 32'h0000CAFE);
    rst = 1; tick(); rst = 0;
    chk("mid_rst_valid", {31'b0, rsp_valid}, 0);
    tick(); tick();
    chk("mid_rst_dropped", {31'b0, rsp_valid}, 0);
    req0_valid = 1; req0_op = 4'b1101; req0_A = 32'h0000BEEF; req0_B = 32'h0000CAFE;
    req1_valid = 1; req1_op = 4'b0010;
    #1;
    chk("mid_rst_prio0", {30'b0, req1_ready, req0_ready}, 32'd1);
    tick(); req0_valid = 0; req1_valid = 0;
    wait_rsp();
    chk("mid_rst_xor", rsp_dout, 32'h00007411);
    chk("mid_rst_id", {31'b0, rsp_id}, 0);
    tick();

    // Withdrawal: a one-cycle req1 pulse during RESP is never served
    rsp_ready = 0;
    issue(0, 4'b0001, 32'h0000BEEF, 32'h0000CAFE);
    wait_rsp();
    req1_valid = 1; req1_op = 4'b0010; #1;
    chk("wd_ready", {31'b0, req1_ready}, 0);
    tick(); req1_valid = 0;
    chk("wd_or", rsp_dout, 32'h0000FEFF);
    rsp_ready = 1;
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("wd_no_rsp", {31'b0, rsp_valid}, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
